mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS datapath.
- Sits between the register-file read ports and the Hi/Lo registers.
- Takes operands from the register-file read ports PA/PB and executes MULT, MULTU, DIV and DIVU.
- Produces a 64-bit result: upper half to HiRegister's PW/HiEnable, lower half to LoRegister's PW/LoEnable.
- One shift-add / restoring-subtract step per cycle. A busy flag is provided for the hazard logic to stall MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and result-half width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- rs_val  input  WIDTH  operand A (multiplicand / dividend); from PA.
- rt_val  input  WIDTH  operand B (multiplier / divisor); from PB.
- cancel  input  1  synchronous abort (pipeline flush).
- busy  output  1  operation in progress.
- hi_out  output  WIDTH  Hi result: product[63:32] or remainder.
- lo_out  output  WIDTH  Lo result: product[31:0] or quotient.
- hi_we  output  1  one-cycle write strobe to HiEnable.
- lo_we  output  1  one-cycle write strobe to LoEnable; always equal to hi_we.

Behaviour:
- Reset and clock
  - One clock (Clk). Reset is asynchronous, active-low (rst_n).
  - While rst_n=0: state=IDLE, counter=0, busy=0, hi_we=lo_we=0, hi_out=lo_out=0, internal operand/accumulator registers=0.
  - Reset asserted mid-operation discards the operation; no strobe is produced.
- States: IDLE, CALC, FIX.
- IDLE
  - start=1 at edge k: latch op, |rs_val|, |rt_val| (absolute values for signed ops, raw for unsigned), and the result signs.
  - Result signs: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
  - Clear accumulator and counter; go to CALC; busy=1 from edge k.
  - start=0: remain in IDLE.
- CALC
  - One iteration per edge, edges k+1 .. k+32; counter increments 0..31.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; partial remainder WIDTH+1 bits wide.
  - The edge with counter==31 moves to FIX.
- FIX (edge k+33)
  - Apply two's-complement negation per the latched signs.
  - Load hi_out/lo_out; assert hi_we=lo_we=1 for exactly this one cycle; busy=0; return to IDLE.
  - Strobe latency is therefore fixed: visible in the cycle after edge k+33. Op and data do not change the latency.
- hi_out/lo_out hold their value until the next FIX, reset, or nothing else; cancel does not clear them.
- start while busy=1 is ignored; no queuing.
- start in the cycle where hi_we=1 (unit already IDLE) is accepted normally.
- cancel=1 in CALC or FIX: return to IDLE next edge, busy=0, no strobe, outputs unchanged.
  - cancel has priority over start and over FIX completion.
  - cancel in IDLE has no effect; start is ignored that cycle.
- Arithmetic rules
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Multiply result is the full 64 bits; there is no overflow.
- Boundary cases
  - Divide by zero (DIV or DIVU): lo_out=32'hFFFFFFFF, hi_out=rs_val (raw), same latency.
  - DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0.
  - MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0. The magnitude path must be WIDTH+1-safe, i.e. treat |0x80000000| as unsigned 2^31.
- The operand ports may change freely after the start edge; the latched copies are used.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003, start pulse at edge k -> busy 1 for edges k..k+32; hi_we=lo_we=1 only in the cycle after edge k+33; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Both with the 33-cycle strobe latency.
- Start MULTU 3*4, then pulse start with DIVU 9/3 at edge k+10 -> second request ignored; single strobe with hi=0, lo=12. Then start DIVU 9/3 in the strobe cycle -> accepted; next strobe lo=3, hi=0.
- Start MULT 5*5, cancel at edge k+15 -> busy=0 next cycle, no strobe, outputs keep the prior result. Start again, drop rst_n at edge k+20 -> immediately busy=0, hi_out=lo_out=0, no strobe after release.

Source files
------------

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the issue logic and mult_div_unit.
//   start/op/rs_val/rt_val/cancel : request side (driven by the master)
//   busy                          : operation in progress (stall MFHI/MFLO)
//   hi_out/lo_out, hi_we/lo_we    : result halves and their write strobes
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             hi_we;
    logic             lo_we;

    modport master (
        output start, op, rs_val, rt_val, cancel,
        input  busy, hi_out, lo_out, hi_we, lo_we
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel,
        output busy, hi_out, lo_out, hi_we, lo_we
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU for the Hi/Lo registers.
//   Clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mdu_if slave (request in, busy/result/strobes out)
// Works on operand magnitudes, one shift-add or restoring-subtract step per
// cycle for WIDTH cycles, then fixes the signs in a final cycle. Latency from
// the start edge to the strobe edge is always WIDTH+1 edges.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic  Clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;        // |A|; shifted left as dividend
    logic [WIDTH-1:0]   b_q, b_d;        // |B|; shifted right as multiplier
    logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or {remainder, quotient}
    logic               neg_q, neg_d;    // product / quotient sign
    logic               rneg_q, rneg_d;  // remainder sign
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               we_q, we_d;

    logic               sa, sb;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem, quo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        sa      = 1'b0;
        sb      = 1'b0;
        sum     = '0;
        rem_sh  = '0;
        ge      = 1'b0;
        prod    = '0;
        rem     = acc_q[2*WIDTH-1:WIDTH];
        quo     = acc_q[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    // op[0]=0 selects the signed variants
                    sa      = !bus.op[0] && bus.rs_val[WIDTH-1];
                    sb      = !bus.op[0] && bus.rt_val[WIDTH-1];
                    // Negating the most negative value yields 2^(WIDTH-1),
                    // which is exactly right when read as unsigned.
                    a_d     = sa ? -bus.rs_val : bus.rs_val;
                    b_d     = sb ? -bus.rt_val : bus.rt_val;
                    op_d    = bus.op;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_q[1]) begin
                        // LSB-first shift-add; carry kept in sum's top bit
                        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                              + {1'b0, (b_q[0] ? a_q : '0)};
                        acc_d = {sum, acc_q[WIDTH-1:1]};
                        b_d   = b_q >> 1;
                    end else begin
                        rem_sh = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
                        ge     = rem_sh >= {1'b0, b_q};
                        a_d    = a_q << 1;
                        acc_d[2*WIDTH-1:WIDTH] = ge ? WIDTH'(rem_sh - {1'b0, b_q})
                                                    : rem_sh[WIDTH-1:0];
                        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ge};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.cancel) begin
                    we_d = 1'b1;
                    if (!op_q[1]) begin
                        prod = neg_q ? -acc_q : acc_q;
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else begin
                        // A zero divisor leaves rem=|A|, so re-applying the
                        // dividend sign restores the raw rs_val.
                        hi_d = rneg_q ? -rem : rem;
                        lo_d = (b_q == '0) ? '1 : (neg_q ? -quo : quo);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.hi_we  = we_q;
    assign bus.lo_we  = we_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected {hi,lo} pushed when a request
// is issued, popped and compared when the write strobe appears.
module tb_mult_div_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .Clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int s0;
    logic [63:0] exp_q[$];

    always @(negedge clk) if (bus.hi_we) strobes++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at #1 after an edge, c0 edges after the start edge.
    task automatic wait_strobe(input int c0, input string tag);
        logic [63:0] e;
        bit seen;
        seen = 0;
        for (int c = c0 + 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.hi_we) begin
                seen = 1;
                chk({tag, "_lat"}, 64'(c), 64'd33);
                chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
                chk({tag, "_lowe"}, 64'(bus.lo_we), 64'd1);
                chk({tag, "_sb"}, 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_hi"}, 64'(bus.hi_out), 64'(e[63:32]));
                    chk({tag, "_lo"}, 64'(bus.lo_out), 64'(e[31:0]));
                end
            end else if (c == 32) begin
                chk({tag, "_busy32"}, 64'(bus.busy), 64'd1);
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
        bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
        exp_q.push_back({eh, el});
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rs_val = $urandom; bus.rt_val = $urandom;  // latched copies must be used
        chk({tag, "_busy0"}, 64'(bus.busy), 64'd1);
        wait_strobe(0, tag);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0; bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_we", 64'({bus.hi_we, bus.lo_we}), 64'd0);
        chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        do_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min");
        do_op(DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_n7_2");
        do_op(DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu_7_2");
        do_op(DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_n2");
        do_op(DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, "divu_by0");
        do_op(DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0");
        do_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");

        // start while busy is ignored
        s0 = strobes;
        bus.start = 1'b1; bus.op = MULTU; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        exp_q.push_back({32'd0, 32'd12});
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = DIVU; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign_busy", 64'(bus.busy), 64'd1);
        wait_strobe(10, "ign");
        // start in the strobe cycle is accepted
        do_op(DIVU, 32'd9, 32'd3, 32'd0, 32'd3, "b2b");
        chk("b2b_count", 64'(strobes - s0), 64'd2);

        // cancel in IDLE: no effect, start ignored
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MULT; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("idle_cancel", 64'(bus.busy), 64'd0);

        // cancel mid-operation
        s0 = strobes;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1 bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        chk("cancel_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("cancel_nostrobe", 64'(strobes - s0), 64'd0);
        chk("cancel_hold", {bus.hi_out, bus.lo_out}, {32'd0, 32'd3});

        // reset mid-operation
        s0 = strobes;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_nostrobe", 64'(strobes - s0), 64'd0);
        chk("arst_idle", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
